// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter
// Frame-level round-robin arbiter that merges NUM_CH AXI-Stream TX sources
// into the single tx_axis input of the 1G MAC wrapper. Frames are never
// interleaved; an inter-frame idle gap of ifg_gap cycles follows every frame,
// and frames longer than MAX_FRAME_LEN beats are truncated (tlast+tuser forced
// on the limit beat) with the remainder drained from the source.
//
// Optional build macro: ETH_TX_FRAME_ARBITER_STATS_EN
//   Adds per-channel saturating frame_count (32 bit) and trunc_count (16 bit)
//   outputs. Without the macro these ports and counters do not exist.
module eth_tx_frame_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 8,
  parameter int MAX_FRAME_LEN = 1522,
  parameter int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       gtx_clk,
  input  logic                       gtx_rst_n,
  input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
  input  logic [NUM_CH-1:0]          s_axis_tvalid,
  input  logic [NUM_CH-1:0]          s_axis_tlast,
  input  logic [NUM_CH-1:0]          s_axis_tuser,
  output logic [NUM_CH-1:0]          s_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tuser,
  input  logic                       m_axis_tready,
  input  logic [7:0]                 ifg_gap,
  output logic [CH_W-1:0]            grant_ch,
  output logic                       busy,
  output logic                       oversize
`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]       frame_count,
  output logic [NUM_CH*16-1:0]       trunc_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Beat index of the last beat allowed in a frame.
  localparam logic [11:0]     LIMIT   = 12'(MAX_FRAME_LEN - 1);
  // Reset grant points at the last channel so the search starts at ch0.
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state;
  logic [11:0]       beat_cnt;
  logic [7:0]        gap_cnt;

  logic [DATA_W-1:0] cur_data;
  logic              cur_valid;
  logic              cur_last;
  logic              cur_user;
  logic              at_limit;
  logic              trunc_beat;
  logic              frame_xfer;
  logic              frame_done;

  // Round-robin search: first requesting channel after 'last', wrapping.
  function automatic logic [CH_W-1:0] pick_next(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
    logic [CH_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last) + i) % NUM_CH;
      if (!found && req[idx]) begin
        sel   = CH_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction
`endif

  // Select the granted channel's stream.
  always_comb begin
    cur_data  = s_axis_tdata[grant_ch*DATA_W +: DATA_W];
    cur_valid = s_axis_tvalid[grant_ch];
    cur_last  = s_axis_tlast[grant_ch];
    cur_user  = s_axis_tuser[grant_ch];
  end

  // A source tlast on the limit beat is a normal end, not a truncation.
  assign at_limit   = (beat_cnt == LIMIT);
  assign trunc_beat = at_limit && !cur_last;
  assign frame_xfer = (state == ST_FRAME) && cur_valid && m_axis_tready;
  assign frame_done = frame_xfer && (cur_last || at_limit);
  assign busy       = (state != ST_IDLE);

  // Output mux and ready steering, decoded from the registered state.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = '0;
    oversize      = 1'b0;
    case (state)
      ST_FRAME: begin
        m_axis_tdata            = cur_data;
        m_axis_tvalid           = cur_valid;
        m_axis_tlast            = cur_last || at_limit;
        m_axis_tuser            = cur_user || trunc_beat;
        s_axis_tready[grant_ch] = m_axis_tready;
        oversize                = frame_xfer && trunc_beat;
      end
      ST_DRAIN: begin
        s_axis_tready[grant_ch] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Arbitration / frame / drain / gap sequencing.
  always_ff @(posedge gtx_clk) begin
    if (!gtx_rst_n) begin
      state    <= ST_IDLE;
      grant_ch <= LAST_CH;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (|s_axis_tvalid) begin
            grant_ch <= pick_next(s_axis_tvalid, grant_ch);
            state    <= ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (frame_xfer) begin
            if (cur_last) begin
              beat_cnt <= '0;
              if (ifg_gap != 8'd0) begin
                gap_cnt <= ifg_gap;
                state   <= ST_GAP;
              end else begin
                state   <= ST_IDLE;
              end
            end else if (at_limit) begin
              beat_cnt <= '0;
              state    <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 12'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (cur_valid && cur_last) begin
            if (ifg_gap != 8'd0) begin
              gap_cnt <= ifg_gap;
              state   <= ST_GAP;
            end else begin
              state   <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt <= 8'd1) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
  // Per-channel saturating counters of completed and truncated frames.
  always_ff @(posedge gtx_clk) begin
    if (!gtx_rst_n) begin
      frame_count <= '0;
      trunc_count <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (frame_done && (int'(grant_ch) == c)) begin
          frame_count[c*32 +: 32] <= sat_inc32(frame_count[c*32 +: 32]);
        end
        if (oversize && (int'(grant_ch) == c)) begin
          trunc_count[c*16 +: 16] <= sat_inc16(trunc_count[c*16 +: 16]);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter
// Directed bench for eth_tx_frame_arbiter with NUM_CH=4, DATA_W=8 and
// MAX_FRAME_LEN=8. Sources are replayed from per-channel beat tables; every
// output beat is logged with its cycle and grant and compared to hand-derived
// expectations. Build with ETH_TX_FRAME_ARBITER_STATS_EN to cover the counters.
module tb_eth_tx_frame_arbiter;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int MAXLEN = 8;
  localparam int CH_W   = 2;

  logic                     gtx_clk = 1'b0;
  logic                     gtx_rst_n = 1'b1;
  logic [NUM_CH*DATA_W-1:0] s_axis_tdata = '0;
  logic [NUM_CH-1:0]        s_axis_tvalid = '0;
  logic [NUM_CH-1:0]        s_axis_tlast = '0;
  logic [NUM_CH-1:0]        s_axis_tuser = '0;
  logic [NUM_CH-1:0]        s_axis_tready;
  logic [DATA_W-1:0]        m_axis_tdata;
  logic                     m_axis_tvalid;
  logic                     m_axis_tlast;
  logic                     m_axis_tuser;
  logic                     m_axis_tready = 1'b1;
  logic [7:0]               ifg_gap = 8'd0;
  logic [CH_W-1:0]          grant_ch;
  logic                     busy;
  logic                     oversize;
`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
  logic [NUM_CH*32-1:0]     frame_count;
  logic [NUM_CH*16-1:0]     trunc_count;
`endif

  always #5 gtx_clk = ~gtx_clk;

  eth_tx_frame_arbiter #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .MAX_FRAME_LEN(MAXLEN)
  ) dut (
    .gtx_clk(gtx_clk),
    .gtx_rst_n(gtx_rst_n),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .ifg_gap(ifg_gap),
    .grant_ch(grant_ch),
    .busy(busy),
    .oversize(oversize)
`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
    ,
    .frame_count(frame_count),
    .trunc_count(trunc_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Source beat tables: {tuser, tlast, tdata}.
  logic [9:0] src_mem [NUM_CH][32];
  int         src_len [NUM_CH];
  int         src_ptr [NUM_CH];

  // Output beat log.
  logic [7:0] out_data [64];
  logic       out_last [64];
  logic       out_user [64];
  int         out_ch   [64];
  int         out_cyc  [64];
  int         n_out;
  int         k;
  int         viol;
  int         ovs_cnt;
  int         rdy_mode;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] bd(input int ch, input int f, input int b);
    return 8'((ch << 6) | (f << 4) | b);
  endfunction

  task automatic load_frame(input int ch, input int f, input int len);
    for (int b = 0; b < len; b++) begin
      src_mem[ch][src_len[ch]] = {1'b0, (b == len - 1), bd(ch, f, b)};
      src_len[ch]++;
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < NUM_CH; c++) begin
      src_len[c] = 0;
      src_ptr[c] = 0;
    end
    n_out    = 0;
    k        = 0;
    viol     = 0;
    ovs_cnt  = 0;
    rdy_mode = 0;
  endtask

  task automatic drive_inputs();
    logic [9:0] beat;
    for (int c = 0; c < NUM_CH; c++) begin
      if (src_ptr[c] < src_len[c]) begin
        beat = src_mem[c][src_ptr[c]];
        s_axis_tvalid[c]                  = 1'b1;
        s_axis_tlast[c]                   = beat[8];
        s_axis_tuser[c]                   = beat[9];
        s_axis_tdata[c*DATA_W +: DATA_W]  = beat[7:0];
      end else begin
        s_axis_tvalid[c]                  = 1'b0;
        s_axis_tlast[c]                   = 1'b0;
        s_axis_tuser[c]                   = 1'b0;
        s_axis_tdata[c*DATA_W +: DATA_W]  = '0;
      end
    end
    m_axis_tready = (rdy_mode == 0) ? 1'b1 : ((k % 2) == 0);
  endtask

  // One clock: drive at negedge, observe 1ns later, handshake at next posedge.
  task automatic cycle();
    @(negedge gtx_clk);
    drive_inputs();
    #1;
    if ((s_axis_tready & ~(4'b0001 << grant_ch)) != 4'b0000) viol++;
    if (m_axis_tvalid && (s_axis_tready != (4'(m_axis_tready) << grant_ch))) viol++;
    if (oversize) ovs_cnt++;
    if (m_axis_tvalid && m_axis_tready && n_out < 64) begin
      out_data[n_out] = m_axis_tdata;
      out_last[n_out] = m_axis_tlast;
      out_user[n_out] = m_axis_tuser;
      out_ch[n_out]   = int'(grant_ch);
      out_cyc[n_out]  = k;
      n_out++;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (s_axis_tready[c] && s_axis_tvalid[c]) src_ptr[c]++;
    end
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    @(negedge gtx_clk);
    drive_inputs();
    gtx_rst_n = 1'b0;
    @(posedge gtx_clk);
    #1;
    check_eq("rst_m_tvalid", m_axis_tvalid, 0);
    check_eq("rst_m_tlast", m_axis_tlast, 0);
    check_eq("rst_m_tuser", m_axis_tuser, 0);
    check_eq("rst_m_tdata", m_axis_tdata, 0);
    check_eq("rst_s_tready", s_axis_tready, 0);
    check_eq("rst_grant", grant_ch, 3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_oversize", oversize, 0);
    @(negedge gtx_clk);
    gtx_rst_n = 1'b1;
  endtask

  initial begin
    // T1: ch0 and ch2 valid, 4-beat frames, no gap.
    clear_all();
    do_reset();
    load_frame(0, 0, 4);
    load_frame(2, 0, 4);
    run(12);
    check_eq("t1_nout", n_out, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("t1_data%0d", i), out_data[i], bd((i < 4) ? 0 : 2, 0, i % 4));
      check_eq($sformatf("t1_last%0d", i), out_last[i], (i % 4) == 3);
    end
    check_eq("t1_grant_a", out_ch[0], 0);
    check_eq("t1_grant_b", out_ch[4], 2);
    check_eq("t1_first_cyc", out_cyc[0], 1);
    check_eq("t1_second_cyc", out_cyc[4], 6);
    check_eq("t1_tready", viol, 0);

    // T2: all channels continuously valid, 3-beat frames.
    clear_all();
    do_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      load_frame(c, 0, 3);
      load_frame(c, 1, 3);
    end
    run(20);
    check_eq("t2_nout", n_out, 15);
    for (int j = 0; j < 5; j++) begin
      check_eq($sformatf("t2_ch%0d", j), out_ch[3*j], j % 4);
      for (int b = 0; b < 3; b++) begin
        check_eq($sformatf("t2_data%0d_%0d", j, b), out_data[3*j+b], bd(j % 4, j / 4, b));
      end
    end
    check_eq("t2_last_cyc", out_cyc[14], 19);
    check_eq("t2_tready", viol, 0);

    // T3: ifg_gap=12, two frames back to back on ch1.
    clear_all();
    do_reset();
    ifg_gap = 8'd12;
    load_frame(1, 0, 2);
    load_frame(1, 1, 2);
    run(20);
    check_eq("t3_nout", n_out, 4);
    check_eq("t3_first_cyc", out_cyc[0], 1);
    check_eq("t3_gap_span", out_cyc[2] - out_cyc[1], 14);
    check_eq("t3_data2", out_data[2], bd(1, 1, 0));
    ifg_gap = 8'd0;

    // T4: 12-beat frame on ch0 truncated at 8; 8-beat frame on ch1 is normal.
    clear_all();
    do_reset();
    load_frame(0, 0, 12);
    load_frame(1, 0, 8);
    run(24);
    check_eq("t4_nout", n_out, 16);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("t4_last%0d", i), out_last[i], 0);
    end
    check_eq("t4_trunc_data", out_data[7], bd(0, 0, 7));
    check_eq("t4_trunc_last", out_last[7], 1);
    check_eq("t4_trunc_user", out_user[7], 1);
    check_eq("t4_oversize", ovs_cnt, 1);
    check_eq("t4_drained", src_ptr[0], 12);
    check_eq("t4_ch1_cyc", out_cyc[8], 14);
    check_eq("t4_ch1_data", out_data[8], bd(1, 0, 0));
    check_eq("t4_limit_last", out_last[15], 1);
    check_eq("t4_limit_user", out_user[15], 0);
`ifdef ETH_TX_FRAME_ARBITER_STATS_EN
    check_eq("t4_fc0", frame_count[31:0], 1);
    check_eq("t4_tc0", trunc_count[15:0], 1);
    check_eq("t4_fc1", frame_count[63:32], 1);
    check_eq("t4_tc1", trunc_count[31:16], 0);
`endif

    // T5: m_axis_tready alternates during a 6-beat frame on ch2.
    clear_all();
    do_reset();
    rdy_mode = 1;
    load_frame(2, 0, 6);
    run(14);
    check_eq("t5_nout", n_out, 6);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("t5_data%0d", i), out_data[i], bd(2, 0, i));
    end
    check_eq("t5_first_cyc", out_cyc[0], 2);
    check_eq("t5_last_cyc", out_cyc[5], 12);
    check_eq("t5_tready", viol, 0);
    rdy_mode = 0;

    // T6: reset mid-frame on ch3, then ch0 wins first.
    clear_all();
    do_reset();
    load_frame(3, 0, 6);
    run(3);
    check_eq("t6_pre_nout", n_out, 2);
    check_eq("t6_pre_busy", busy, 1);
    load_frame(0, 0, 2);
    do_reset();
    n_out = 0;
    k     = 0;
    run(4);
    check_eq("t6_nout", n_out, 3);
    check_eq("t6_ch_a", out_ch[0], 0);
    check_eq("t6_data0", out_data[0], bd(0, 0, 0));
    check_eq("t6_data1", out_data[1], bd(0, 0, 1));
    check_eq("t6_first_cyc", out_cyc[0], 0);
    check_eq("t6_ch_b", out_ch[2], 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
